// File: rtl/ddr_ctrl_arbit.sv
// rtl/ddr_ctrl_arbit.sv - SDRAM command arbiter and pin multiplexer for init/refresh/write/read sub-controllers
module ddr_ctrl_arbit #(
    parameter int ADDR_WIDTH    = 13,
    parameter int BA_WIDTH      = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  init_end_i,
    input  logic [3:0]            init_cmd_i,
    input  logic [BA_WIDTH-1:0]   init_ba_i,
    input  logic [ADDR_WIDTH-1:0] init_addr_i,
    input  logic                  aref_req_i,
    input  logic                  aref_end_i,
    input  logic [3:0]            aref_cmd_i,
    input  logic [BA_WIDTH-1:0]   aref_ba_i,
    input  logic [ADDR_WIDTH-1:0] aref_addr_i,
    input  logic                  wr_req_i,
    input  logic                  wr_end_i,
    input  logic [3:0]            wr_cmd_i,
    input  logic [BA_WIDTH-1:0]   wr_ba_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                  wr_sdram_en_i,
    input  logic [DATA_WIDTH-1:0] wr_sdram_data_i,
    input  logic                  rd_req_i,
    input  logic                  rd_end_i,
    input  logic [3:0]            rd_cmd_i,
    input  logic [BA_WIDTH-1:0]   rd_ba_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  aref_en_o,
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic                  sdram_cs_n_o,
    output logic                  sdram_ras_n_o,
    output logic                  sdram_cas_n_o,
    output logic                  sdram_we_n_o,
    output logic [BA_WIDTH-1:0]   sdram_ba_o,
    output logic [ADDR_WIDTH-1:0] sdram_addr_o,
    output logic                  sdram_dq_oe_o,
    output logic [DATA_WIDTH-1:0] sdram_dq_o,
    output logic                  timeout_err_o
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    // Counter must hold GRANT_TIMEOUT-1; one extra value of headroom keeps the width math simple.
    localparam int              CNT_W    = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] grant_cnt;
    logic             timeout_hit;
    logic             in_grant;
    logic [3:0]       cmd_sel;

    assign in_grant = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);

    // Next-state: fixed-priority arbitration, own-end release, watchdog release when no end arrives.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_end_i) state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req_i)     state_nxt = ST_AREF;
                else if (wr_req_i)  state_nxt = ST_WRITE;
                else if (rd_req_i)  state_nxt = ST_READ;
            end
            ST_AREF: begin
                if (aref_end_i) state_nxt = ST_ARBIT;
                else if (grant_cnt == CNT_LAST) begin
                    state_nxt   = ST_ARBIT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_end_i) state_nxt = ST_ARBIT;
                else if (grant_cnt == CNT_LAST) begin
                    state_nxt   = ST_ARBIT;
                    timeout_hit = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_end_i) state_nxt = ST_ARBIT;
                else if (grant_cnt == CNT_LAST) begin
                    state_nxt   = ST_ARBIT;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // State, grant-length counter (zero outside a grant, so it starts at 0 on entry) and error pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_INIT;
            grant_cnt     <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            timeout_err_o <= timeout_hit;
            if (in_grant && (state_nxt == state)) grant_cnt <= grant_cnt + 1'b1;
            else                                  grant_cnt <= '0;
        end
    end

    assign aref_en_o = (state == ST_AREF);
    assign wr_en_o   = (state == ST_WRITE);
    assign rd_en_o   = (state == ST_READ);

    // Pin mux: pass the owning sub-controller straight through; idle arbitration drives NOP.
    always_comb begin
        cmd_sel      = CMD_NOP;
        sdram_ba_o   = '1;
        sdram_addr_o = '1;
        case (state)
            ST_INIT: begin
                cmd_sel      = init_cmd_i;
                sdram_ba_o   = init_ba_i;
                sdram_addr_o = init_addr_i;
            end
            ST_AREF: begin
                cmd_sel      = aref_cmd_i;
                sdram_ba_o   = aref_ba_i;
                sdram_addr_o = aref_addr_i;
            end
            ST_WRITE: begin
                cmd_sel      = wr_cmd_i;
                sdram_ba_o   = wr_ba_i;
                sdram_addr_o = wr_addr_i;
            end
            ST_READ: begin
                cmd_sel      = rd_cmd_i;
                sdram_ba_o   = rd_ba_i;
                sdram_addr_o = rd_addr_i;
            end
            default: begin
                cmd_sel      = CMD_NOP;
                sdram_ba_o   = '1;
                sdram_addr_o = '1;
            end
        endcase
    end

    assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = cmd_sel;

    assign sdram_dq_oe_o = wr_en_o && wr_sdram_en_i;
    assign sdram_dq_o    = sdram_dq_oe_o ? wr_sdram_data_i : '0;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// tb/tb_ddr_ctrl_arbit.sv - scoreboard bench for ddr_ctrl_arbit
module tb_ddr_ctrl_arbit;

    localparam int T = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end_i;
    logic [3:0]  init_cmd_i;
    logic [1:0]  init_ba_i;
    logic [12:0] init_addr_i;
    logic        aref_req_i, aref_end_i;
    logic [3:0]  aref_cmd_i;
    logic [1:0]  aref_ba_i;
    logic [12:0] aref_addr_i;
    logic        wr_req_i, wr_end_i;
    logic [3:0]  wr_cmd_i;
    logic [1:0]  wr_ba_i;
    logic [12:0] wr_addr_i;
    logic        wr_sdram_en_i;
    logic [15:0] wr_sdram_data_i;
    logic        rd_req_i, rd_end_i;
    logic [3:0]  rd_cmd_i;
    logic [1:0]  rd_ba_i;
    logic [12:0] rd_addr_i;
    logic        aref_en_o, wr_en_o, rd_en_o;
    logic        sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o;
    logic [1:0]  sdram_ba_o;
    logic [12:0] sdram_addr_o;
    logic        sdram_dq_oe_o;
    logic [15:0] sdram_dq_o;
    logic        timeout_err_o;

    always #5 sys_clk = ~sys_clk;

    ddr_ctrl_arbit #(.ADDR_WIDTH(13), .BA_WIDTH(2), .DATA_WIDTH(16), .GRANT_TIMEOUT(T)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end_i(init_end_i),
        .init_cmd_i(init_cmd_i), .init_ba_i(init_ba_i), .init_addr_i(init_addr_i),
        .aref_req_i(aref_req_i), .aref_end_i(aref_end_i), .aref_cmd_i(aref_cmd_i),
        .aref_ba_i(aref_ba_i), .aref_addr_i(aref_addr_i),
        .wr_req_i(wr_req_i), .wr_end_i(wr_end_i), .wr_cmd_i(wr_cmd_i), .wr_ba_i(wr_ba_i),
        .wr_addr_i(wr_addr_i), .wr_sdram_en_i(wr_sdram_en_i), .wr_sdram_data_i(wr_sdram_data_i),
        .rd_req_i(rd_req_i), .rd_end_i(rd_end_i), .rd_cmd_i(rd_cmd_i), .rd_ba_i(rd_ba_i),
        .rd_addr_i(rd_addr_i),
        .aref_en_o(aref_en_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
        .sdram_cs_n_o(sdram_cs_n_o), .sdram_ras_n_o(sdram_ras_n_o),
        .sdram_cas_n_o(sdram_cas_n_o), .sdram_we_n_o(sdram_we_n_o),
        .sdram_ba_o(sdram_ba_o), .sdram_addr_o(sdram_addr_o),
        .sdram_dq_oe_o(sdram_dq_oe_o), .sdram_dq_o(sdram_dq_o), .timeout_err_o(timeout_err_o)
    );

    typedef struct packed {
        logic [2:0]  gnt;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        oe;
        logic [15:0] dq;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // reference model: 0 INIT, 1 ARBIT, 2 AREF, 3 WRITE, 4 READ
    int m_state;
    int m_cnt;
    bit m_err;

    int n_checks = 0;
    int n_errors = 0;
    int rd_seen, err_seen;
    bit fix_wdata = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ends;
        bit grant;
        if (sys_rst) begin
            m_state = 0; m_cnt = 0; m_err = 0;
        end else begin
            m_err = 0;
            grant = (m_state >= 2);
            ends  = (m_state == 2 && aref_end_i) || (m_state == 3 && wr_end_i) ||
                    (m_state == 4 && rd_end_i);
            if (m_state == 0) begin
                if (init_end_i) m_state = 1;
            end else if (m_state == 1) begin
                m_cnt = 0;
                if (aref_req_i)    m_state = 2;
                else if (wr_req_i) m_state = 3;
                else if (rd_req_i) m_state = 4;
            end else if (grant) begin
                if (ends) begin
                    m_state = 1; m_cnt = 0;
                end else if (m_cnt == T - 1) begin
                    m_state = 1; m_cnt = 0; m_err = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt = {m_state == 2, m_state == 3, m_state == 4};
        case (m_state)
            0: begin e.cmd = init_cmd_i; e.ba = init_ba_i; e.addr = init_addr_i; end
            2: begin e.cmd = aref_cmd_i; e.ba = aref_ba_i; e.addr = aref_addr_i; end
            3: begin e.cmd = wr_cmd_i;   e.ba = wr_ba_i;   e.addr = wr_addr_i;   end
            4: begin e.cmd = rd_cmd_i;   e.ba = rd_ba_i;   e.addr = rd_addr_i;   end
            default: begin e.cmd = 4'b0111; e.ba = 2'b11; e.addr = 13'h1fff; end
        endcase
        e.oe  = (m_state == 3) && wr_sdram_en_i;
        e.dq  = e.oe ? wr_sdram_data_i : 16'h0;
        e.err = m_err;
        return e;
    endfunction

    // One clock: scramble the sub-controller buses, predict, clock, then compare at negedge.
    task automatic tick();
        exp_t e;
        init_ba_i = 2'($urandom); init_addr_i = 13'($urandom);
        aref_cmd_i = 4'($urandom); aref_ba_i = 2'($urandom); aref_addr_i = 13'($urandom);
        wr_cmd_i = 4'($urandom); wr_ba_i = 2'($urandom); wr_addr_i = 13'($urandom);
        rd_cmd_i = 4'($urandom); rd_ba_i = 2'($urandom); rd_addr_i = 13'($urandom);
        if (!fix_wdata) begin
            wr_sdram_en_i = 1'($urandom); wr_sdram_data_i = 16'($urandom);
        end
        model_step();
        exp_q.push_back(model_out());
        @(posedge sys_clk);
        @(negedge sys_clk);
        e = exp_q.pop_front();
        check("grants", {29'd0, aref_en_o, wr_en_o, rd_en_o}, {29'd0, e.gnt});
        check("cmd", {28'd0, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o}, {28'd0, e.cmd});
        check("ba", {30'd0, sdram_ba_o}, {30'd0, e.ba});
        check("addr", {19'd0, sdram_addr_o}, {19'd0, e.addr});
        check("dq_oe", {31'd0, sdram_dq_oe_o}, {31'd0, e.oe});
        check("dq", {16'd0, sdram_dq_o}, {16'd0, e.dq});
        check("timeout_err", {31'd0, timeout_err_o}, {31'd0, e.err});
        if (rd_en_o) rd_seen++;
        if (timeout_err_o) err_seen++;
    endtask

    initial begin
        sys_rst = 1; init_end_i = 0; init_cmd_i = 4'b0010;
        aref_req_i = 0; aref_end_i = 0; wr_req_i = 0; wr_end_i = 0;
        rd_req_i = 0; rd_end_i = 0; wr_sdram_en_i = 0; wr_sdram_data_i = 0;
        m_state = 0; m_cnt = 0; m_err = 0;

        // reset, then init_end on the 10th cycle with a refresh request already waiting
        tick(); tick();
        check("rst_cmd_pre", {28'd0, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o}, 32'h2);
        sys_rst = 0;
        aref_req_i = 1;
        repeat (9) tick();
        init_end_i = 1; tick(); init_end_i = 0;
        check("init_exit_nop", {28'd0, sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o}, 32'h7);
        check("init_exit_nogrant", {31'd0, aref_en_o}, 32'd0);
        tick();
        check("first_grant", {31'd0, aref_en_o}, 32'd1);
        aref_req_i = 0; aref_end_i = 1; tick(); aref_end_i = 0;

        // all three requests together: refresh, then write, then read, NOP between each
        aref_req_i = 1; wr_req_i = 1; rd_req_i = 1; init_end_i = 1;
        tick(); aref_req_i = 0;
        check("prio_aref", {29'd0, aref_en_o, wr_en_o, rd_en_o}, 32'b100);
        tick(); aref_end_i = 1; tick(); aref_end_i = 0;
        check("gap_after_aref", {29'd0, aref_en_o, wr_en_o, rd_en_o}, 32'b000);
        fix_wdata = 1; wr_sdram_en_i = 1; wr_sdram_data_i = 16'hA5A5;
        tick(); wr_req_i = 0;
        check("prio_wr_dq", {16'd0, sdram_dq_o}, 32'hA5A5);
        rd_end_i = 1; tick(); rd_end_i = 0;
        wr_end_i = 1; tick(); wr_end_i = 0;
        tick(); rd_req_i = 0;
        check("rd_grant", {31'd0, rd_en_o}, 32'd1);
        check("rd_no_dq", {15'd0, sdram_dq_oe_o, sdram_dq_o}, 32'd0);
        rd_end_i = 1; tick(); rd_end_i = 0; fix_wdata = 0; init_end_i = 0;

        // refresh request arriving in the middle of a write waits for the write to end
        wr_req_i = 1; tick(); wr_req_i = 0;
        tick(); aref_req_i = 1; tick(); tick();
        check("wr_held", {31'd0, wr_en_o}, 32'd1);
        wr_end_i = 1; tick(); wr_end_i = 0;
        check("gap_before_aref", {31'd0, aref_en_o}, 32'd0);
        tick(); aref_req_i = 0;
        check("aref_after_wr", {31'd0, aref_en_o}, 32'd1);
        aref_end_i = 1; tick(); aref_end_i = 0;

        // read grant that never ends: forced release after T cycles
        rd_seen = 0; err_seen = 0;
        rd_req_i = 1; tick(); rd_req_i = 0;
        repeat (12) tick();
        check("timeout_rd_cycles", rd_seen, T);
        check("timeout_pulses", err_seen, 1);

        // end arriving in the last allowed cycle wins over the watchdog
        rd_seen = 0; err_seen = 0;
        rd_req_i = 1; tick(); rd_req_i = 0;
        repeat (T - 1) tick();
        rd_end_i = 1; tick(); rd_end_i = 0;
        repeat (3) tick();
        check("end_at_limit_cycles", rd_seen, T);
        check("end_at_limit_pulses", err_seen, 0);

        // reset in the middle of a write
        fix_wdata = 1; wr_sdram_en_i = 1;
        wr_req_i = 1; tick(); wr_req_i = 0; tick();
        sys_rst = 1; tick();
        check("rst_mid_wr_gnt", {29'd0, aref_en_o, wr_en_o, rd_en_o}, 32'd0);
        check("rst_mid_wr_oe", {31'd0, sdram_dq_oe_o}, 32'd0);
        sys_rst = 0; wr_req_i = 1; tick(); tick();
        check("init_holds", {31'd0, wr_en_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
